mole_pick_server: RTL and testbench
===================================

Name: mole_pick_server

Overview:
- Responder side of the mole-draw request/done handshake used by the game controller.
- On each request, returns a mole index not yet drawn since the last clear. Seeds each search from the external LFSR value. Flags pool exhaustion so the FSM can end the round.
- Sits between lfsr_prng and the game FSM; its output drives mole_pattern decoding.

Parameters:
- WIDTH, 3, index width; pool size N = 2**WIDTH (8 moles).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rnd_num  input  WIDTH  random seed from lfsr_prng; sampled only when a request is accepted
- req  input  1  draw request; level-sampled in IDLE
- clear  input  1  synchronous pool reset (new game)
- selected_number  output  WIDTH  last granted index; held until next grant
- done  output  1  one-cycle pulse; selected_number is valid in the same cycle
- all_selected  output  1  high when every index has been drawn
- busy  output  1  high while in PROBE
- req_reject  output  1  one-cycle pulse when req arrives in IDLE with all_selected=1
- used_mask  output  N  bit i=1 means index i has been drawn

Behaviour:
- Reset (async, rst=1): state=IDLE; cand=0; used_mask=0; selected_number=0; done=0; all_selected=0; busy=0; req_reject=0. All outputs are registered.
- States: IDLE, PROBE.
- IDLE, clear=1:
  - used_mask<=0; req is ignored this cycle.
- IDLE, req=1 and all_selected=0:
  - cand<=rnd_num; state->PROBE.
- IDLE, req=1 and all_selected=1:
  - req_reject<=1 for one cycle; state stays IDLE; no done.
- PROBE, used_mask[cand]=0:
  - selected_number<=cand; used_mask[cand]<=1; done<=1; state->IDLE.
- PROBE, used_mask[cand]=1:
  - cand<=cand+1, wrapping N-1 -> 0; stay in PROBE.
  - The pool is non-empty on entry, so a free slot is always found within N probes.
- Latency:
  - req high in cycle 0 -> done high in cycle 2+k, where k is the number of occupied slots skipped.
  - Min 2, max N+1 (9).
- done, req_reject: high for exactly one cycle, otherwise 0.
- busy = (state==PROBE).
- all_selected = &used_mask, registered and updated on the same edge as the commit. It rises in the same cycle as the done for the Nth draw.
- req in PROBE: ignored, not queued.
- req held high through done: the IDLE cycle in which done is high samples req and starts a new draw. Back-to-back draws therefore take 2+k cycles each.
- clear in PROBE:
  - Aborts to IDLE; used_mask<=0; no done.
  - selected_number keeps its old value; all_selected<=0.
- clear and a commit on the same edge: clear wins. Mask stays 0, no done pulse, selected_number unchanged.
- rnd_num changing while in PROBE has no effect; only the accept-cycle value is used.
- Reset asserted mid-PROBE: immediate return to reset values; any done scheduled for the next edge is dropped.

Test Plan:
- Reset, then clear; req=1 for one cycle with rnd_num=5 -> done in cycle 2, selected_number=5, used_mask=0x20, all_selected=0.
- Probe wrap: with used_mask=0xE0, req with rnd_num=6 -> probes 6,7,0; done in cycle 4, selected_number=0, used_mask=0xE1.
- Exhaustion:
  - Hold req=1 with rnd_num fixed at 3 -> eight dones, selected 3,4,5,6,7,0,1,2.
  - all_selected rises with the 8th done and used_mask=0xFF.
  - The next IDLE cycle with req=1 gives req_reject=1, no done.
- Abort: used_mask=0x7F, req with rnd_num=0 -> busy; assert clear in cycle 3 -> no done ever, used_mask=0x00, selected_number unchanged, state IDLE.
- Collision: clear and the commit cycle coincide (used_mask=0x00, rnd_num=2, clear in cycle 1) -> no done, used_mask=0x00.
- Async reset: pulse rst for less than one clock mid-PROBE -> all outputs 0 immediately, no later done. A new req afterwards completes normally.

Source files
------------

// File: rtl/mole_pick_server.sv
// Draw server for the mole game: each request returns an index not drawn since
// the last clear, starting the search at the LFSR seed and walking upward.
module mole_pick_server #(
   parameter int WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    rnd_num,
   input  logic                req,
   input  logic                clear,
   output logic [WIDTH-1:0]    selected_number,
   output logic                done,
   output logic                all_selected,
   output logic                busy,
   output logic                req_reject,
   output logic [2**WIDTH-1:0] used_mask
);
   localparam int N = 2**WIDTH;

   typedef enum logic {IDLE, PROBE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_cand;
   logic [N-1:0]     w_cand_bit;

   assign w_cand_bit = {{(N-1){1'b0}}, 1'b1} << r_cand;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_cand          <= '0;
         used_mask       <= '0;
         selected_number <= '0;
         done            <= 1'b0;
         all_selected    <= 1'b0;
         busy            <= 1'b0;
         req_reject      <= 1'b0;
      end else begin
         done       <= 1'b0;
         req_reject <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clear) begin
                  used_mask    <= '0;
                  all_selected <= 1'b0;
               end else if (req) begin
                  if (all_selected) begin
                     req_reject <= 1'b1;
                  end else begin
                     r_cand  <= rnd_num;
                     r_state <= PROBE;
                     busy    <= 1'b1;
                  end
               end
            end
            PROBE: begin
               // clear beats a same-edge commit: no grant, pool emptied
               if (clear) begin
                  used_mask    <= '0;
                  all_selected <= 1'b0;
                  r_state      <= IDLE;
                  busy         <= 1'b0;
               end else if (!used_mask[r_cand]) begin
                  selected_number <= r_cand;
                  used_mask       <= used_mask | w_cand_bit;
                  all_selected    <= &(used_mask | w_cand_bit);
                  done            <= 1'b1;
                  r_state         <= IDLE;
                  busy            <= 1'b0;
               end else begin
                  r_cand <= r_cand + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mole_pick_server.sv
// Scoreboard bench for mole_pick_server: expected grants are queued by the
// stimulus and matched by a monitor whenever done is seen.
module tb_mole_pick_server;
   logic       clk;
   logic       rst;
   logic [2:0] rnd_num;
   logic       req;
   logic       clear;
   logic [2:0] selected_number;
   logic       done;
   logic       all_selected;
   logic       busy;
   logic       req_reject;
   logic [7:0] used_mask;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] mask;
      logic       all;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   mole_pick_server #(.WIDTH(3)) dut (
      .clk(clk), .rst(rst), .rnd_num(rnd_num), .req(req), .clear(clear),
      .selected_number(selected_number), .done(done), .all_selected(all_selected),
      .busy(busy), .req_reject(req_reject), .used_mask(used_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " sel"},  selected_number, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " all"},  all_selected, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " rej"},  req_reject, 0);
      chk({tag, " mask"}, used_mask, 0);
   endtask

   // One draw: req for one cycle, done expected exactly lat cycles later.
   task automatic draw(input logic [2:0] rnd, input logic [2:0] es, input logic [7:0] em,
                       input logic ea, input int lat);
      exp_t e;
      e.sel = es; e.mask = em; e.all = ea;
      q.push_back(e);
      rnd_num = rnd;
      req     = 1'b1;
      step();
      req = 1'b0;
      for (int c = 1; c < lat; c++) begin
         chk("no early done", done, 0);
         step();
      end
      chk("latency done", done, 1);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            chk("unexpected done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("grant sel",  selected_number, e.sel);
            chk("grant mask", used_mask, e.mask);
            chk("grant all",  all_selected, e.all);
         end
      end
   end

   initial begin
      logic [7:0] m;
      rst = 1'b1; req = 1'b0; clear = 1'b0; rnd_num = 3'd0;
      #2;
      chk_all_zero("reset");
      step();
      rst = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;

      // basic draw and probe wrap
      draw(3'd5, 3'd5, 8'h20, 1'b0, 2);
      draw(3'd6, 3'd6, 8'h60, 1'b0, 2);
      draw(3'd7, 3'd7, 8'hE0, 1'b0, 2);
      draw(3'd6, 3'd0, 8'hE1, 1'b0, 4);

      // exhaustion with req held and a fixed seed
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear mask", used_mask, 0);
      m = 8'h00;
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         e.sel = 3'((3 + i) % 8);
         m = m | (8'h01 << e.sel);
         e.mask = m;
         e.all  = (i == 7);
         q.push_back(e);
      end
      rnd_num = 3'd3;
      req     = 1'b1;
      for (int c = 0; c < 200; c++) begin
         step();
         if (q.size() == 0) break;
      end
      chk("exhaust drained", q.size(), 0);
      chk("reject pulse", req_reject, 1);
      chk("reject no done", done, 0);
      chk("exhaust all", all_selected, 1);
      req = 1'b0;
      step();
      chk("reject one cycle", req_reject, 0);

      // abort with clear mid-probe
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 7; i++)
         draw(3'(i), 3'(i), 8'((16'h1 << (i + 1)) - 1), 1'b0, 2);
      chk("pre-abort mask", used_mask, 8'h7F);
      rnd_num = 3'd0;
      req     = 1'b1;
      step();
      req = 1'b0;
      chk("abort busy c1", busy, 1);
      step();
      step();
      chk("abort busy c3", busy, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort mask", used_mask, 0);
      chk("abort sel", selected_number, 6);
      chk("abort all", all_selected, 0);
      repeat (10) step();
      chk("abort no done", q.size(), 0);

      // clear coinciding with the commit edge
      rnd_num = 3'd2;
      req     = 1'b1;
      step();
      req   = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("collide done", done, 0);
      chk("collide mask", used_mask, 0);
      chk("collide sel", selected_number, 6);
      chk("collide busy", busy, 0);
      repeat (3) step();

      // short async reset mid-probe
      rnd_num = 3'd4;
      req     = 1'b1;
      step();
      req = 1'b0;
      chk("pre-reset busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("async");
      #1 rst = 1'b0;
      repeat (4) step();
      chk("post-reset done", done, 0);
      chk("post-reset busy", busy, 0);
      draw(3'd4, 3'd4, 8'h10, 1'b0, 2);
      step();

      chk("scoreboard empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
